// File: rtl/booth_mul_sequencer_if.sv
// booth_mul_sequencer_if: requester, result and multiplier-side signals of booth_mul_sequencer.
// master is the surrounding system (requesters, consumer, multiplier); slave is the sequencer.
interface booth_mul_sequencer_if #(
    parameter int N = 32
);
    logic           req0_valid;
    logic           req1_valid;
    logic           req0_ready;
    logic           req1_ready;
    logic [N-1:0]   req0_x;
    logic [N-1:0]   req0_y;
    logic [N-1:0]   req1_x;
    logic [N-1:0]   req1_y;
    logic           res_valid;
    logic           res_ready;
    logic [2*N-1:0] res_data;
    logic           res_id;
    logic           mul_rst_n;
    logic [N-1:0]   mul_x;
    logic [N-1:0]   mul_y;
    logic [2*N-1:0] mul_product;

    modport master (
        output req0_valid, req1_valid, req0_x, req0_y, req1_x, req1_y, res_ready, mul_product,
        input  req0_ready, req1_ready, res_valid, res_data, res_id, mul_rst_n, mul_x, mul_y
    );

    modport slave (
        input  req0_valid, req1_valid, req0_x, req0_y, req1_x, req1_y, res_ready, mul_product,
        output req0_ready, req1_ready, res_valid, res_data, res_id, mul_rst_n, mul_x, mul_y
    );
endinterface

// File: rtl/booth_mul_sequencer.sv
// booth_mul_sequencer: round-robin two-port front end and timing sequencer for a shared radix-8 Booth multiplier.
// Optional BOOTH_SEQ_ZERO_BYPASS_EN: a zero operand skips the multiplier and completes the cycle after accept.
module booth_mul_sequencer #(
    parameter int N = 32
) (
    input logic                 clk,
    input logic                 rst,
    booth_mul_sequencer_if.slave bus
);
    localparam int ITER = (N + 5) / 3;
    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPT, DONE} state_t;

    state_t        state;
    logic          rr;
    logic          grant1;
    logic          accept;
    logic          zero;
    logic [CW-1:0] cnt;
    logic [N-1:0]  sel_x;
    logic [N-1:0]  sel_y;

    always_comb begin
        grant1 = bus.req1_valid && (!bus.req0_valid || rr);
        bus.req0_ready = state == IDLE && bus.req0_valid && !grant1;
        bus.req1_ready = state == IDLE && grant1;
        accept = bus.req0_ready || bus.req1_ready;
        sel_x = grant1 ? bus.req1_x : bus.req0_x;
        sel_y = grant1 ? bus.req1_y : bus.req0_y;
    end

`ifdef BOOTH_SEQ_ZERO_BYPASS_EN
    assign zero = sel_x == '0 || sel_y == '0;
`else
    assign zero = 1'b0;
`endif

    // mul_rst_n is registered with the state, so it is low exactly in IDLE, LOAD and DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rr            <= 1'b0;
            cnt           <= '0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_id    <= 1'b0;
            bus.mul_x     <= '0;
            bus.mul_y     <= '0;
            bus.mul_rst_n <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    bus.mul_x  <= sel_x;
                    bus.mul_y  <= sel_y;
                    bus.res_id <= grant1;
                    rr         <= !grant1;
                    if (zero) begin
                        state         <= DONE;
                        bus.res_data  <= '0;
                        bus.res_valid <= 1'b1;
                    end else begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    state         <= RUN;
                    cnt           <= CW'(ITER - 1);
                    bus.mul_rst_n <= 1'b1;
                end
                RUN: if (cnt == '0) state <= CAPT;
                     else cnt <= cnt - 1'b1;
                CAPT: begin
                    state         <= DONE;
                    bus.res_data  <= bus.mul_product;
                    bus.res_valid <= 1'b1;
                    bus.mul_rst_n <= 1'b0;
                end
                DONE: if (bus.res_ready) begin
                    state         <= IDLE;
                    bus.res_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mul_sequencer.sv
// tb_booth_mul_sequencer: vector table, hand-written corner sequences and random traffic against a
// behavioural model; a cycle-counting multiplier model supplies mul_product.
module tb_booth_mul_sequencer;
    localparam int N = 32;
    localparam int ITER = (N + 5) / 3;
`ifdef BOOTH_SEQ_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    booth_mul_sequencer_if #(.N(N)) bus ();
    booth_mul_sequencer #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    function automatic logic [31:0] rnd();
        return ($urandom_range(5) == 0) ? 32'd0 : $urandom();
    endfunction

    // Product is only meaningful after ITER clocks out of reset; before that it shows a marker pattern
    int mcnt = 0;
    logic [63:0] mprod;
    assign bus.mul_product = mprod;
    always @(posedge clk or negedge bus.mul_rst_n)
        if (!bus.mul_rst_n) begin
            mcnt  <= 0;
            mprod <= '0;
        end else begin
            mcnt  <= mcnt + 1;
            mprod <= (mcnt + 1 >= ITER) ? ref_mul(bus.mul_x, bus.mul_y)
                                        : 64'hA5A5_0000_0000_0000 + 64'(mcnt);
        end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input bit v0, input bit v1, input logic [31:0] x0, input logic [31:0] y0,
                          input logic [31:0] x1, input logic [31:0] y1, input bit eg,
                          input logic [63:0] exp, input bit zero, input bit hold, input string nm);
        int n;
        int bad;
        logic [31:0] gx;
        logic [31:0] gy;
        bus.req0_valid = v0;
        bus.req0_x = x0;
        bus.req0_y = y0;
        bus.req1_valid = v1;
        bus.req1_x = x1;
        bus.req1_y = y1;
        #1;
        n = 0;
        while (!(bus.req0_ready || bus.req1_ready) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({nm, "_wait"}, 128'(n), 128'(0));
        check({nm, "_grant"}, {bus.req1_ready, bus.req0_ready}, eg ? 2'b10 : 2'b01);
        gx = eg ? x1 : x0;
        gy = eg ? y1 : y0;
        @(posedge clk);
        #1;
        if (!hold) begin
            if (eg) bus.req1_valid = 1'b0;
            else bus.req0_valid = 1'b0;
        end
        check({nm, "_ops"}, {bus.mul_x, bus.mul_y}, {gx, gy});
        n = 1;
        bad = 0;
        while (!bus.res_valid && n < 40) begin
            if (bus.mul_rst_n !== (n >= 2)) bad++;
            @(posedge clk);
            #1;
            n++;
        end
        check({nm, "_lat"}, 128'(n), 128'((BYP && zero) ? 1 : ITER + 3));
        check({nm, "_mulrst_seq"}, 128'(bad), 128'(0));
        check({nm, "_data"}, bus.res_data, exp);
        check({nm, "_id"}, bus.res_id, eg);
        check({nm, "_done_mulrst"}, bus.mul_rst_n, 1'b0);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
    endtask

    typedef struct {
        bit          k;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] p;
    } vec_t;

    vec_t tv [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit rr_m;
        bit p0;
        bit p1;
        bit g;
        logic [31:0] x0;
        logic [31:0] y0;
        logic [31:0] x1;
        logic [31:0] y1;
        logic [31:0] gx;
        logic [31:0] gy;
        tv[0] = '{1'b0, 32'd7,         32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
        tv[1] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        tv[2] = '{1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001};
        tv[3] = '{1'b1, 32'd0,         32'd123,       64'h0};
        tv[4] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1};
        tv[5] = '{1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000};
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_x = '0;
        bus.req0_y = '0;
        bus.req1_x = '0;
        bus.req1_y = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
        check("rst_res_valid", bus.res_valid, 1'b0);
        check("rst_res_data", bus.res_data, 64'h0);
        check("rst_res_id", bus.res_id, 1'b0);
        check("rst_mul_ops", {bus.mul_x, bus.mul_y}, 64'h0);
        check("rst_mul_rst_n", bus.mul_rst_n, 1'b0);

        for (int i = 0; i < 6; i++)
            run_op(!tv[i].k, tv[i].k, tv[i].x, tv[i].y, tv[i].x, tv[i].y, tv[i].k, tv[i].p,
                   tv[i].x == 0 || tv[i].y == 0, 1'b0, $sformatf("tv%0d", i));

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++)
            run_op(1'b1, 1'b1, 32'd5, 32'd6, 32'hFFFF_FFFC, 32'd9, i[0],
                   i[0] ? 64'hFFFF_FFFF_FFFF_FFDC : 64'd30, 1'b0, 1'b1, $sformatf("cont%0d", i));

        bus.req0_x = 32'd11;
        bus.req0_y = 32'hFFFF_FFFE;
        bus.req1_x = 32'd3;
        bus.req1_y = 32'd3;
        #1;
        check("bp_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
        @(posedge clk);
        #1;
        n = 0;
        while (!bus.res_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_data", bus.res_data, 64'hFFFF_FFFF_FFFF_FFEA);
        repeat (20) begin
            @(posedge clk);
            #1;
            check("bp_hold", {bus.res_valid, bus.req0_ready, bus.req1_ready, bus.res_id, bus.res_data},
                  {1'b1, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFEA});
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        check("bp_next", {bus.req1_ready, bus.req0_ready}, 2'b10);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        n = 0;
        while (!bus.res_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_next_result", {bus.res_id, bus.res_data}, {1'b1, 64'd9});
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;

        bus.req0_valid = 1'b1;
        bus.req0_x = 32'd100;
        bus.req0_y = 32'd200;
        #1;
        check("mr_grant", bus.req0_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mr_state", {bus.res_valid, bus.mul_rst_n, bus.res_data}, 66'h0);
        n = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.res_valid || bus.mul_rst_n) n++;
        end
        check("mr_quiet", 128'(n), 128'(0));
        run_op(1'b1, 1'b0, 32'd12, 32'hFFFF_FFF4, 32'd0, 32'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF70,
               1'b0, 1'b0, "mr_fresh");

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rr_m = 1'b0;
        p0 = 1'b0;
        p1 = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        for (int i = 0; i < 24; i++) begin
            if (!p0 && $urandom_range(1) == 1) begin p0 = 1'b1; x0 = rnd(); y0 = rnd(); end
            if (!p1 && $urandom_range(1) == 1) begin p1 = 1'b1; x1 = rnd(); y1 = rnd(); end
            if (!p0 && !p1) begin p0 = 1'b1; x0 = rnd(); y0 = rnd(); end
            g = (p0 && p1) ? rr_m : p1;
            gx = g ? x1 : x0;
            gy = g ? y1 : y0;
            run_op(p0, p1, x0, y0, x1, y1, g, ref_mul(gx, gy), gx == 0 || gy == 0, 1'b0,
                   $sformatf("rand%0d", i));
            if (g) p1 = 1'b0;
            else p0 = 1'b0;
            rr_m = !g;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
